// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//
// Decode/issue stage sitting between fetch and execute. It holds the scalar
// and vector register files, generates the sign-extended immediate, tracks
// pending destination writes in a per-register scoreboard (one for each file)
// and stalls the incoming instruction on RAW/WAW hazards. Decoded operands are
// handed to execute through a single valid/ready output register.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   defined   - a source whose writeback arrives in the same cycle is not a
//               hazard; its operand is forwarded from the writeback port.
//   undefined - no forwarding; the dependent instruction waits one more cycle
//               and reads the freshly written register file.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           upstream handshake (in_ready combinational)
//   inst, pc_plus_4, imm_type     instruction word, PC+4, immediate format
//   is_vec, rs1/rs2/rd _en/_addr  file select and register usage
//   flush                         kills held and incoming instruction
//   s_wb_*                        scalar writeback (clears busy, writes file)
//   v_wb_*                        vector writeback with per-lane mask
//   out_valid / out_ready         downstream handshake
//   out_s1/s2, out_v1/v2          scalar and vector operands
//   out_imm, out_pc_plus_4        immediate and forwarded PC+4
//   out_is_vec, out_rd_en, out_rd forwarded destination control
// -----------------------------------------------------------------------------
module decode_issue_stage #(
    parameter int  XLEN   = 36,
    parameter int  VLANES = 4,
    parameter int  VWIDTH = 32,
    parameter int  NREGS  = 32,
    localparam int RA     = $clog2(NREGS),
    localparam int VW     = VLANES * VWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc_plus_4,
    input  logic [3:0]        imm_type,
    input  logic              is_vec,
    input  logic              rs1_en,
    input  logic              rs2_en,
    input  logic              rd_en,
    input  logic [RA-1:0]     rs1_addr,
    input  logic [RA-1:0]     rs2_addr,
    input  logic [RA-1:0]     rd_addr,
    input  logic              flush,
    input  logic              s_wb_en,
    input  logic [RA-1:0]     s_wb_addr,
    input  logic [XLEN-1:0]   s_wb_data,
    input  logic              v_wb_en,
    input  logic [RA-1:0]     v_wb_addr,
    input  logic [VLANES-1:0] v_wb_mask,
    input  logic [VW-1:0]     v_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_s1,
    output logic [XLEN-1:0]   out_s2,
    output logic [VW-1:0]     out_v1,
    output logic [VW-1:0]     out_v2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc_plus_4,
    output logic              out_is_vec,
    output logic              out_rd_en,
    output logic [RA-1:0]     out_rd
);

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Slots 0 and 1 are sources, slot 2 is the destination.
    localparam logic [2:0] SRC_SLOTS = 3'b011;

    // Immediate: selected bit fields concatenated, sign-extended from the top.
    function automatic logic [XLEN-1:0] imm_gen(input logic [24:0] w, input logic [3:0] t);
        logic [XLEN-1:0] r;
        r = '0;
        case (t)
            4'd0:    r = {{(XLEN-25){w[24]}}, w[24:0]};
            4'd1:    r = {{(XLEN-21){w[24]}}, w[24:20], w[15:0]};
            4'd2:    r = {{(XLEN-22){w[21]}}, w[21:0]};
            4'd3:    r = {{(XLEN-15){w[14]}}, w[14:0]};
            4'd4:    r = {{(XLEN-19){w[18]}}, w[18:0]};
            4'd5:    r = {{(XLEN-15){w[24]}}, w[24:20], w[9:0]};
            4'd6:    r = {{(XLEN-11){w[14]}}, w[14:4]};
            4'd7:    r = {{(XLEN-16){w[24]}}, w[24:20], w[14:4]};
            4'd8:    r = {{(XLEN-11){w[24]}}, w[24:20], w[9:4]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-lane merge: lanes with mask set come from new_v, others from old_v.
    function automatic logic [VW-1:0] lane_merge(input logic [VW-1:0] old_v,
                                                 input logic [VW-1:0] new_v,
                                                 input logic [VLANES-1:0] m);
        logic [VW-1:0] r;
        r = old_v;
        for (int i = 0; i < VLANES; i++) begin
            if (m[i]) begin
                r[i*VWIDTH +: VWIDTH] = new_v[i*VWIDTH +: VWIDTH];
            end else begin
                r[i*VWIDTH +: VWIDTH] = old_v[i*VWIDTH +: VWIDTH];
            end
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] s_operand(input logic use_it, input logic fwd,
                                                  input logic [XLEN-1:0] arr,
                                                  input logic [XLEN-1:0] wbd);
        logic [XLEN-1:0] r;
        if (!use_it) begin
            r = '0;
        end else if (fwd) begin
            r = wbd;
        end else begin
            r = arr;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] v_operand(input logic use_it, input logic fwd,
                                                input logic [VW-1:0] arr,
                                                input logic [VW-1:0] wbd,
                                                input logic [VLANES-1:0] m);
        logic [VW-1:0] r;
        if (!use_it) begin
            r = '0;
        end else if (fwd) begin
            r = lane_merge(arr, wbd, m);
        end else begin
            r = arr;
        end
        return r;
    endfunction

    // Register files and scoreboards
    logic [XLEN-1:0]  s_rf_q [NREGS];
    logic [VW-1:0]    v_rf_q [NREGS];
    logic [NREGS-1:0] busy_s_q, busy_s_d, busy_v_q, busy_v_d;
    logic [NREGS-1:0] clr_s_s, clr_v_s, set_s_s, set_v_s;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_s1_q, out_s1_d, out_s2_q, out_s2_d;
    logic [VW-1:0]    out_v1_q, out_v1_d, out_v2_q, out_v2_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic             out_is_vec_q, out_is_vec_d, out_rd_en_q, out_rd_en_d;
    logic [RA-1:0]    out_rd_q, out_rd_d;

    logic             hazard_s, accept_s, issue_s;
    logic [RA-1:0]    slot_addr_s [3];
    logic [2:0]       slot_en_s;
    logic [2:0]       slot_busy_s, slot_wb_s, slot_held_s;
    logic [XLEN-1:0]  rd_s1_s, rd_s2_s;
    logic [VW-1:0]    rd_v1_s, rd_v2_s;
    logic             unused_inst_s;

    assign unused_inst_s  = ^inst[31:25];

    assign slot_addr_s[0] = rs1_addr;
    assign slot_addr_s[1] = rs2_addr;
    assign slot_addr_s[2] = rd_addr;
    assign slot_en_s      = {rd_en, rs2_en, rs1_en};

    // Per-slot hazard: busy in the selected file (a same-cycle writeback only
    // rescues sources, and only with forwarding), or the held instruction
    // targets the same register and has not issued yet.
    always_comb begin
        hazard_s    = 1'b0;
        slot_busy_s = 3'b000;
        slot_wb_s   = 3'b000;
        slot_held_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            slot_busy_s[k] = is_vec ? busy_v_q[slot_addr_s[k]] : busy_s_q[slot_addr_s[k]];
            slot_wb_s[k]   = is_vec ? (v_wb_en && (v_wb_addr == slot_addr_s[k]))
                                    : (s_wb_en && (s_wb_addr == slot_addr_s[k]));
            slot_held_s[k] = out_valid_q && out_rd_en_q && (out_is_vec_q == is_vec)
                             && (out_rd_q == slot_addr_s[k]);
            if (slot_en_s[k] && (slot_held_s[k] ||
                (slot_busy_s[k] && !(SRC_SLOTS[k] && BYPASS && slot_wb_s[k])))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign in_ready = !flush && !hazard_s && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;
    assign issue_s  = out_valid_q && out_ready;

    // Operand read; scalar r0 is hardwired to zero.
    assign rd_s1_s = s_operand(rs1_en && !is_vec && (rs1_addr != '0),
                               BYPASS && s_wb_en && (s_wb_addr == rs1_addr),
                               s_rf_q[rs1_addr], s_wb_data);
    assign rd_s2_s = s_operand(rs2_en && !is_vec && (rs2_addr != '0),
                               BYPASS && s_wb_en && (s_wb_addr == rs2_addr),
                               s_rf_q[rs2_addr], s_wb_data);
    assign rd_v1_s = v_operand(rs1_en && is_vec,
                               BYPASS && v_wb_en && (v_wb_addr == rs1_addr),
                               v_rf_q[rs1_addr], v_wb_data, v_wb_mask);
    assign rd_v2_s = v_operand(rs2_en && is_vec,
                               BYPASS && v_wb_en && (v_wb_addr == rs2_addr),
                               v_rf_q[rs2_addr], v_wb_data, v_wb_mask);

    // Scoreboard: clear on writeback, set on issue; set is applied last so it
    // wins on the same bit. Scalar r0 is never busy.
    assign clr_s_s  = s_wb_en ? (NREGS'(1) << s_wb_addr) : '0;
    assign clr_v_s  = v_wb_en ? (NREGS'(1) << v_wb_addr) : '0;
    assign set_s_s  = (issue_s && out_rd_en_q && !out_is_vec_q) ? (NREGS'(1) << out_rd_q) : '0;
    assign set_v_s  = (issue_s && out_rd_en_q &&  out_is_vec_q) ? (NREGS'(1) << out_rd_q) : '0;
    assign busy_s_d = ((busy_s_q & ~clr_s_s) | set_s_s) & ~NREGS'(1);
    assign busy_v_d = (busy_v_q & ~clr_v_s) | set_v_s;

    // Output register next state: load on accept, drop on flush or issue.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_s1_d     = out_s1_q;
        out_s2_d     = out_s2_q;
        out_v1_d     = out_v1_q;
        out_v2_d     = out_v2_q;
        out_imm_d    = out_imm_q;
        out_pc_d     = out_pc_q;
        out_is_vec_d = out_is_vec_q;
        out_rd_en_d  = out_rd_en_q;
        out_rd_d     = out_rd_q;
        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_s1_d     = rd_s1_s;
            out_s2_d     = rd_s2_s;
            out_v1_d     = rd_v1_s;
            out_v2_d     = rd_v2_s;
            out_imm_d    = imm_gen(inst[24:0], imm_type);
            out_pc_d     = pc_plus_4;
            out_is_vec_d = is_vec;
            out_rd_en_d  = rd_en;
            out_rd_d     = rd_addr;
        end else if (flush || issue_s) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // Output register and scoreboard state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_s1_q     <= '0;
            out_s2_q     <= '0;
            out_v1_q     <= '0;
            out_v2_q     <= '0;
            out_imm_q    <= '0;
            out_pc_q     <= '0;
            out_is_vec_q <= 1'b0;
            out_rd_en_q  <= 1'b0;
            out_rd_q     <= '0;
            busy_s_q     <= '0;
            busy_v_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_s1_q     <= out_s1_d;
            out_s2_q     <= out_s2_d;
            out_v1_q     <= out_v1_d;
            out_v2_q     <= out_v2_d;
            out_imm_q    <= out_imm_d;
            out_pc_q     <= out_pc_d;
            out_is_vec_q <= out_is_vec_d;
            out_rd_en_q  <= out_rd_en_d;
            out_rd_q     <= out_rd_d;
            busy_s_q     <= busy_s_d;
            busy_v_q     <= busy_v_d;
        end
    end

    // Register file writes; vector writes touch only masked lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                s_rf_q[i] <= '0;
                v_rf_q[i] <= '0;
            end
        end else begin
            if (s_wb_en && (s_wb_addr != '0)) begin
                s_rf_q[s_wb_addr] <= s_wb_data;
            end
            if (v_wb_en) begin
                v_rf_q[v_wb_addr] <= lane_merge(v_rf_q[v_wb_addr], v_wb_data, v_wb_mask);
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_s1        = out_s1_q;
    assign out_s2        = out_s2_q;
    assign out_v1        = out_v1_q;
    assign out_v2        = out_v2_q;
    assign out_imm       = out_imm_q;
    assign out_pc_plus_4 = out_pc_q;
    assign out_is_vec    = out_is_vec_q;
    assign out_rd_en     = out_rd_en_q;
    assign out_rd        = out_rd_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// -----------------------------------------------------------------------------
// Testbench for decode_issue_stage. Random instructions, flushes, stalls and
// writebacks are driven each cycle; a transaction-level reference model
// (register values, queues of outstanding writers, one held slot) predicts
// in_ready/out_valid and the record execute should receive. Expected records
// are queued at accept; a separate monitor pops and compares on each issue.
// -----------------------------------------------------------------------------
module tb_decode_issue_stage;
    localparam int XLEN = 36, VLANES = 4, VWIDTH = 32, NREGS = 32, RA = 5;
    localparam int VW = VLANES * VWIDTH;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, is_vec, rs1_en, rs2_en, rd_en, flush;
    logic [31:0] inst;
    logic [XLEN-1:0] pc_plus_4, s_wb_data;
    logic [3:0] imm_type;
    logic [RA-1:0] rs1_addr, rs2_addr, rd_addr, s_wb_addr, v_wb_addr;
    logic s_wb_en, v_wb_en, out_valid, out_ready, out_is_vec, out_rd_en;
    logic [VLANES-1:0] v_wb_mask;
    logic [VW-1:0] v_wb_data, out_v1, out_v2;
    logic [XLEN-1:0] out_s1, out_s2, out_imm, out_pc_plus_4;
    logic [RA-1:0] out_rd;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc_plus_4(pc_plus_4), .imm_type(imm_type), .is_vec(is_vec),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .flush(flush),
        .s_wb_en(s_wb_en), .s_wb_addr(s_wb_addr), .s_wb_data(s_wb_data),
        .v_wb_en(v_wb_en), .v_wb_addr(v_wb_addr), .v_wb_mask(v_wb_mask), .v_wb_data(v_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_s1(out_s1), .out_s2(out_s2),
        .out_v1(out_v1), .out_v2(out_v2), .out_imm(out_imm), .out_pc_plus_4(out_pc_plus_4),
        .out_is_vec(out_is_vec), .out_rd_en(out_rd_en), .out_rd(out_rd)
    );

    typedef struct packed {
        logic [XLEN-1:0] s1, s2;
        logic [VW-1:0]   v1, v2;
        logic [XLEN-1:0] imm, pc;
        logic            vec, rden;
        logic [RA-1:0]   rd;
    } rec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t exp_q[$];

    // Reference model state
    logic [XLEN-1:0] m_s [NREGS];
    logic [VW-1:0]   m_v [NREGS];
    int   pend_s[$];
    int   pend_v[$];
    bit   m_held, m_held_vec, m_held_rden;
    int   m_held_rd;

    task automatic chk(input string nm, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit in_q(input int q[$], input int a);
        foreach (q[i]) if (q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Immediate from the format table: concatenate fields, sign-extend.
    function automatic logic [XLEN-1:0] imm_model(input logic [31:0] w, input int t);
        int hi[2]; int lo[2]; int nf; int n; longint acc;
        nf = 0; n = 0; acc = 0; hi = '{0, 0}; lo = '{0, 0};
        case (t)
            0: begin nf = 1; hi[0] = 24; lo[0] = 0; end
            1: begin nf = 2; hi[0] = 24; lo[0] = 20; hi[1] = 15; lo[1] = 0; end
            2: begin nf = 1; hi[0] = 21; lo[0] = 0; end
            3: begin nf = 1; hi[0] = 14; lo[0] = 0; end
            4: begin nf = 1; hi[0] = 18; lo[0] = 0; end
            5: begin nf = 2; hi[0] = 24; lo[0] = 20; hi[1] = 9;  lo[1] = 0; end
            6: begin nf = 1; hi[0] = 14; lo[0] = 4; end
            7: begin nf = 2; hi[0] = 24; lo[0] = 20; hi[1] = 14; lo[1] = 4; end
            8: begin nf = 2; hi[0] = 24; lo[0] = 20; hi[1] = 9;  lo[1] = 4; end
            default: nf = 0;
        endcase
        for (int f = 0; f < nf; f++)
            for (int b = hi[f]; b >= lo[f]; b--) begin
                acc = (acc << 1) | longint'(w[b]);
                n++;
            end
        if (n > 0 && ((acc >> (n - 1)) & 64'sd1) != 0) acc = acc - (longint'(1) << n);
        return acc[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] s_val(input int a);
        if (a == 0) return '0;
        if (BYP && s_wb_en && int'(s_wb_addr) == a) return s_wb_data;
        return m_s[a];
    endfunction

    function automatic logic [VW-1:0] v_val(input int a);
        logic [VW-1:0] r;
        r = m_v[a];
        if (BYP && v_wb_en && int'(v_wb_addr) == a)
            for (int i = 0; i < VLANES; i++)
                if (v_wb_mask[i]) r[i*VWIDTH +: VWIDTH] = v_wb_data[i*VWIDTH +: VWIDTH];
        return r;
    endfunction

    task automatic clear_inputs();
        in_valid = 0; inst = '0; pc_plus_4 = '0; imm_type = '0; is_vec = 0;
        rs1_en = 0; rs2_en = 0; rd_en = 0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        flush = 0; out_ready = 0; s_wb_en = 0; s_wb_addr = '0; s_wb_data = '0;
        v_wb_en = 0; v_wb_addr = '0; v_wb_mask = '0; v_wb_data = '0;
    endtask

    task automatic drive_random();
        int a;
        in_valid  = ($urandom_range(0, 3) != 0);
        inst      = $urandom;
        imm_type  = 4'($urandom_range(0, 15));
        pc_plus_4 = XLEN'({$urandom, $urandom});
        is_vec    = ($urandom_range(0, 2) == 0);
        rs1_en = $urandom_range(0, 1); rs2_en = $urandom_range(0, 1); rd_en = $urandom_range(0, 1);
        rs1_addr = RA'($urandom_range(0, 7)); rs2_addr = RA'($urandom_range(0, 7));
        rd_addr  = RA'($urandom_range(0, 7));
        flush     = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        s_wb_en = 0; v_wb_en = 0;
        s_wb_data = XLEN'({$urandom, $urandom});
        v_wb_data = {$urandom, $urandom, $urandom, $urandom};
        v_wb_mask = 4'($urandom_range(0, 15));
        if (pend_s.size() > 0 && $urandom_range(0, 2) == 0) begin
            s_wb_en = 1; s_wb_addr = RA'(pend_s[$urandom_range(0, pend_s.size() - 1)]);
        end else if ($urandom_range(0, 9) == 0) begin
            a = $urandom_range(0, 7);
            if (!in_q(pend_s, a)) begin s_wb_en = 1; s_wb_addr = RA'(a); end
        end
        if (pend_v.size() > 0 && $urandom_range(0, 2) == 0) begin
            v_wb_en = 1; v_wb_addr = RA'(pend_v[$urandom_range(0, pend_v.size() - 1)]);
        end else if ($urandom_range(0, 9) == 0) begin
            a = $urandom_range(0, 7);
            if (!in_q(pend_v, a)) begin v_wb_en = 1; v_wb_addr = RA'(a); end
        end
    endtask

    // One cycle of the reference model, evaluated after inputs settle.
    task automatic model_step();
        bit hz, exp_ready, accept, issue, en, busy, wbh, held;
        int a;
        rec_t r;
        hz = 0;
        for (int k = 0; k < 3; k++) begin
            en = (k == 0) ? rs1_en : (k == 1) ? rs2_en : rd_en;
            a  = (k == 0) ? int'(rs1_addr) : (k == 1) ? int'(rs2_addr) : int'(rd_addr);
            busy = is_vec ? in_q(pend_v, a) : in_q(pend_s, a);
            wbh  = is_vec ? (v_wb_en && int'(v_wb_addr) == a) : (s_wb_en && int'(s_wb_addr) == a);
            held = m_held && m_held_rden && (m_held_vec == is_vec) && (m_held_rd == a);
            if (en && (held || (busy && !(k < 2 && BYP && wbh)))) hz = 1;
        end
        exp_ready = !flush && !hz && (!m_held || out_ready);
        chk("in_ready", XLEN'(in_ready), XLEN'(exp_ready));
        chk("out_valid", XLEN'(out_valid), XLEN'(m_held));
        accept = in_valid && exp_ready;
        issue  = m_held && out_ready;
        if (accept) begin
            r.s1   = (rs1_en && !is_vec) ? s_val(int'(rs1_addr)) : '0;
            r.s2   = (rs2_en && !is_vec) ? s_val(int'(rs2_addr)) : '0;
            r.v1   = (rs1_en && is_vec) ? v_val(int'(rs1_addr)) : '0;
            r.v2   = (rs2_en && is_vec) ? v_val(int'(rs2_addr)) : '0;
            r.imm  = imm_model(inst, int'(imm_type));
            r.pc   = pc_plus_4;
            r.vec  = is_vec; r.rden = rd_en; r.rd = rd_addr;
            exp_q.push_back(r);
        end
        if (s_wb_en) begin
            foreach (pend_s[i]) if (pend_s[i] == int'(s_wb_addr)) begin pend_s.delete(i); break; end
            if (s_wb_addr != 0) m_s[s_wb_addr] = s_wb_data;
        end
        if (v_wb_en) begin
            foreach (pend_v[i]) if (pend_v[i] == int'(v_wb_addr)) begin pend_v.delete(i); break; end
            for (int i = 0; i < VLANES; i++)
                if (v_wb_mask[i]) m_v[v_wb_addr][i*VWIDTH +: VWIDTH] = v_wb_data[i*VWIDTH +: VWIDTH];
        end
        if (issue && m_held_rden) begin
            if (m_held_vec) pend_v.push_back(m_held_rd);
            else if (m_held_rd != 0) pend_s.push_back(m_held_rd);
        end
        if (accept) begin
            m_held = 1; m_held_vec = is_vec; m_held_rden = rd_en; m_held_rd = int'(rd_addr);
        end else if (issue) begin
            m_held = 0;
        end else if (flush && m_held) begin
            m_held = 0;
            void'(exp_q.pop_back());
        end
    endtask

    // Monitor: compare every record execute accepts against the scoreboard.
    always begin
        rec_t got, exp;
        @(negedge clk);
        #4;
        if (!rst && out_valid && out_ready) begin
            got = '{out_s1, out_s2, out_v1, out_v2, out_imm, out_pc_plus_4, out_is_vec, out_rd_en, out_rd};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got %h expected no issue", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL issue_record: got %h expected %h", got, exp);
                end
            end
        end
    end

    initial begin
        foreach (m_s[i]) begin m_s[i] = '0; m_v[i] = '0; end
        m_held = 0; m_held_vec = 0; m_held_rden = 0; m_held_rd = 0;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", XLEN'(out_valid), '0);
        chk("rst_out_s1", out_s1, '0);
        chk("rst_out_imm", out_imm, '0);
        chk("rst_out_v1_any", XLEN'(|out_v1), '0);
        chk("rst_out_rd", XLEN'(out_rd), '0);
        rst = 1'b0;

        // First instruction: 15-bit immediate with its sign bit set.
        @(negedge clk);
        clear_inputs();
        in_valid = 1; inst = 32'h0000_4001; imm_type = 4'd3;
        #2 model_step();
        @(negedge clk);
        chk("first_out_valid", XLEN'(out_valid), XLEN'(1));
        chk("imm_type3", out_imm, 36'hFFFFFC001);
        clear_inputs();
        #2 model_step();

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            drive_random();
            #2 model_step();
        end

        // Drain: let everything held issue.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_inputs();
            out_ready = 1;
            #2 model_step();
        end
        @(negedge clk);
        chk("queue_drained", XLEN'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
